// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the slave state enum used by ahb_slave_mem.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

    // Little-endian lane mask; misaligned halfwords fall back to the aligned pair.
    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            HSIZE_BYTE: return 4'b0001 << addr_lo;
            HSIZE_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// DEPTH x 32 storage: byte-enable synchronous write port, asynchronous read port.
module ahb_slave_ram #(
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave with optional wait states.
// Define AHB_SLAVE_ERR_RESP_EN for two-cycle ERROR responses on bad transfers.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [1:0]  htrans,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic          write;
        logic [3:0]    lanes;
        logic [AW-1:0] idx;
    } aphase_t;

    slv_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    aphase_t     ap_q, ap_d;

    logic [31:0] offset;
    logic        can_accept;
    logic        accept;
    logic        err_xfer;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic        unused_bits;

    assign offset     = haddr - BASE_ADDR;
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_ACCESS) || (state_q == ST_ERR2);
    assign accept     = can_accept && hsel && hready &&
                        ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

`ifdef AHB_SLAVE_ERR_RESP_EN
    assign err_xfer = (|offset[31:AW+2]) ||
                      (hsize > HSIZE_WORD) ||
                      ((hsize == HSIZE_HALF) && offset[0]) ||
                      ((hsize == HSIZE_WORD) && (offset[1:0] != 2'b00));
    assign unused_bits = ^hburst;
`else
    assign err_xfer    = 1'b0;
    assign unused_bits = ^{hburst, offset[31:AW+2]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ap_d    = ap_q;
        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = ST_ACCESS;
                end
            end
`ifdef AHB_SLAVE_ERR_RESP_EN
            ST_ERR1: state_d = ST_ERR2;
`endif
            // IDLE, ACCESS and ERR2 all complete a data phase and may take a new address phase.
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    ap_d.write = hwrite;
                    ap_d.lanes = byte_lanes(hsize, offset[1:0]);
                    ap_d.idx   = offset[AW+1:2];
                    if (err_xfer) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES != 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 3'(WAIT_STATES);
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ap_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ap_q    <= ap_d;
        end
    end

    // Gated by hresetn so a reset edge never commits a half-finished write.
    assign ram_we = hresetn && (state_q == ST_ACCESS) && ap_q.write;

    ahb_slave_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (hclk),
        .we_i    (ram_we),
        .be_i    (ap_q.lanes),
        .addr_i  (ap_q.idx),
        .wdata_i (hwdata),
        .rdata_o (ram_rdata)
    );

    assign hreadyout = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    assign hrdata    = ((state_q == ST_ACCESS) && !ap_q.write) ? ram_rdata : '0;

`ifdef AHB_SLAVE_ERR_RESP_EN
    assign hresp = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
    assign hresp = HRESP_OKAY;
`endif

endmodule
